piece_drop_ctrl: RTL and testbench

//  Move-execution stage sitting directly upstream of the win checkers (diagonal/row/column).

---
 rtl/connect4_pkg.sv | 27 ++
 rtl/column_scanner.sv | 27 ++
 rtl/piece_drop_ctrl.sv | 129 ++++++++++++
 tb/tb_piece_drop_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board geometry, cell codes, move FSM
// states and the flat board cell index helper used by the win checkers.
package connect4_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int ROW_W = 3;
  localparam int COL_W = 3;
  localparam int CNT_W = 6;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_PLACE = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  // Cell index of (r,c) in board_flat; the cell occupies bits [2*idx +: 2].
  function automatic int idx(input int r, input int c);
    return r * COLS + c;
  endfunction

endpackage

// File: rtl/column_scanner.sv
// Looks up one cell of the board for the SCAN state: reports whether
// cell(row,col) holds a piece and whether the column is off the board.
module column_scanner
  import connect4_pkg::*;
#(
  parameter int ROWS  = connect4_pkg::ROWS,
  parameter int COLS  = connect4_pkg::COLS,
  parameter int ROW_W = connect4_pkg::ROW_W,
  parameter int COL_W = connect4_pkg::COL_W
) (
  input  logic [2*ROWS*COLS-1:0] board_flat,
  input  logic [COL_W-1:0]       col,
  input  logic [ROW_W-1:0]       row,
  output logic                   occupied,
  output logic                   col_invalid
);

  // Cell lookup; an off-board column or row never reads the board.
  always_comb begin
    col_invalid = (int'(col) >= COLS);
    occupied    = 1'b0;
    if (!col_invalid && (int'(row) < ROWS)) begin
      occupied = (board_flat[2*(int'(row)*COLS + int'(col)) +: 2] != CELL_EMPTY);
    end
  end

endmodule

// File: rtl/piece_drop_ctrl.sv
// Move execution stage: accepts a column, scans upward one row per cycle
// for the lowest empty cell, writes the current player's piece there and
// presents the placement to the win checkers. Owns the board register.
//
// Handshake: a move is taken on a rising edge where move_valid && move_ready
// are both high; move_col is sampled only on that edge. Every accepted move
// ends in exactly one one-cycle pulse: place_valid (piece written, board_flat
// already shows it) or move_err (column full or off the board).
module piece_drop_ctrl
  import connect4_pkg::*;
#(
  parameter int ROWS  = connect4_pkg::ROWS,
  parameter int COLS  = connect4_pkg::COLS,
  parameter int ROW_W = connect4_pkg::ROW_W,
  parameter int COL_W = connect4_pkg::COL_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_game,
  input  logic                   game_over,
  input  logic                   move_valid,
  input  logic [COL_W-1:0]       move_col,
  output logic                   move_ready,
  output logic                   place_valid,
  output logic [ROW_W-1:0]       place_row,
  output logic [COL_W-1:0]       place_col,
  output logic [1:0]             place_player,
  output logic                   move_err,
  output logic [1:0]             cur_player,
  output logic                   board_full,
  output logic [2*ROWS*COLS-1:0] board_flat,
  output state_t                 dbg_state
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROWS * COLS);
  localparam logic [ROW_W-1:0] TOP_ROW  = ROW_W'(ROWS - 1);

  state_t                 state_q, state_d;
  logic [COL_W-1:0]       col_q;
  logic [ROW_W-1:0]       scan_row;
  logic [2*ROWS*COLS-1:0] board_q;
  logic [1:0]             player_q;
  logic [CNT_W-1:0]       count_q;
  logic                   full_q;
  logic                   occupied;
  logic                   col_invalid;
  logic                   accept;
  logic                   land;

  column_scanner #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_scanner (
    .board_flat  (board_q),
    .col         (col_q),
    .row         (scan_row),
    .occupied    (occupied),
    .col_invalid (col_invalid)
  );

  // Next state and handshake/pulse outputs. Off-board columns are rejected
  // from the first SCAN cycle, so their error pulse lands one cycle after
  // acceptance like a row-0 placement would.
  always_comb begin
    state_d     = state_q;
    move_ready  = (state_q == ST_IDLE) && !game_over && !full_q;
    place_valid = (state_q == ST_PLACE);
    move_err    = (state_q == ST_ERR);
    accept      = move_valid && move_ready;
    land        = (state_q == ST_SCAN) && !col_invalid && !occupied;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (col_invalid)              state_d = ST_ERR;
        else if (!occupied)           state_d = ST_PLACE;
        else if (scan_row == TOP_ROW) state_d = ST_ERR;
      end
      ST_PLACE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, board, player, fill count and placement registers; new_game
  // clears everything exactly like reset and aborts any move in flight.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      scan_row     <= '0;
      board_q      <= '0;
      player_q     <= CELL_P1;
      count_q      <= '0;
      full_q       <= 1'b0;
      place_row    <= '0;
      place_col    <= '0;
      place_player <= CELL_EMPTY;
    end else begin
      state_q <= state_d;
      if (accept) begin
        col_q    <= move_col;
        scan_row <= '0;
      end
      if (land) begin
        board_q[2*(int'(scan_row)*COLS + int'(col_q)) +: 2] <= player_q;
        place_row    <= scan_row;
        place_col    <= col_q;
        place_player <= player_q;
      end else if ((state_q == ST_SCAN) && !col_invalid && (scan_row != TOP_ROW)) begin
        scan_row <= scan_row + 1'b1;
      end
      if (state_q == ST_PLACE) begin
        player_q <= (player_q == CELL_P1) ? CELL_P2 : CELL_P1;
        if (count_q != FULL_CNT) count_q <= count_q + 1'b1;
        if (count_q + 1'b1 == FULL_CNT) full_q <= 1'b1;
      end
    end
  end

  assign cur_player = player_q;
  assign board_full = full_q;
  assign board_flat = board_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_piece_drop_ctrl.sv
// Directed bench for piece_drop_ctrl: inputs driven and outputs sampled on
// the falling edge; a small board model supplies expected board_flat.
module tb_piece_drop_ctrl;
  import connect4_pkg::*;

  localparam int NR = 6;
  localparam int NC = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 new_game;
  logic                 game_over;
  logic                 move_valid;
  logic [2:0]           move_col;
  logic                 move_ready;
  logic                 place_valid;
  logic [2:0]           place_row;
  logic [2:0]           place_col;
  logic [1:0]           place_player;
  logic                 move_err;
  logic [1:0]           cur_player;
  logic                 board_full;
  logic [2*NR*NC-1:0]   board_flat;
  state_t               dbg_state;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_board [NR][NC];

  // clock
  always #5 clk = ~clk;

  piece_drop_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .new_game     (new_game),
    .game_over    (game_over),
    .move_valid   (move_valid),
    .move_col     (move_col),
    .move_ready   (move_ready),
    .place_valid  (place_valid),
    .place_row    (place_row),
    .place_col    (place_col),
    .place_player (place_player),
    .move_err     (move_err),
    .cur_player   (cur_player),
    .board_full   (board_full),
    .board_flat   (board_flat),
    .dbg_state    (dbg_state)
  );

  function automatic logic [2*NR*NC-1:0] exp_flat();
    logic [2*NR*NC-1:0] f;
    f = '0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        f[2*(r*NC+c) +: 2] = exp_board[r][c];
    return f;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        exp_board[r][c] = 2'b00;
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    clear_model();
  endtask

  // Presents one move for a single cycle, then waits (bounded) for the
  // resulting pulse. lat counts cycles after the acceptance cycle T.
  // kind: 0 = nothing seen, 1 = place_valid, 2 = move_err.
  task automatic do_move(input int col, output int lat, output int kind);
    kind = 0;
    lat  = 0;
    checks++;
    if (move_ready !== 1'b1) begin
      errors++;
      $display("FAIL move_ready_before_move col=%0d: got %b want 1", col, move_ready);
    end
    move_valid = 1'b1;
    move_col   = 3'(col);
    @(negedge clk);
    move_valid = 1'b0;
    move_col   = ~3'(col);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      if (place_valid || move_err) begin
        kind = place_valid ? 1 : 2;
        break;
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if ((place_valid && move_err) || kind == 0) begin
      errors++;
      $display("FAIL move_outcome col=%0d: place_valid=%b move_err=%b want exactly one pulse",
               col, place_valid, move_err);
    end
  endtask

  // Places a piece and checks latency, position and player against
  // hand-supplied values; leaves the bench one cycle later back in IDLE.
  task automatic place_expect(input int col, input int row, input logic [1:0] player,
                              input int exp_lat);
    int lat, kind;
    do_move(col, lat, kind);
    checks++;
    if (kind !== 1 || lat !== exp_lat || place_row !== 3'(row) || place_col !== 3'(col) ||
        place_player !== player) begin
      errors++;
      $display("FAIL place col=%0d: kind=%0d lat=%0d row=%0d col=%0d player=%b want kind=1 lat=%0d row=%0d col=%0d player=%b",
               col, kind, lat, place_row, place_col, place_player, exp_lat, row, col, player);
    end
    exp_board[row][col] = player;
    checks++;
    if (board_flat !== exp_flat()) begin
      errors++;
      $display("FAIL board_at_place col=%0d: got %h want %h", col, board_flat, exp_flat());
    end
    @(negedge clk);
    checks++;
    if (cur_player !== ((player == 2'b01) ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL cur_player_toggle col=%0d: got %b", col, cur_player);
    end
  endtask

  task automatic err_expect(input int col, input int exp_lat);
    int lat, kind;
    logic [1:0] player_before;
    player_before = cur_player;
    do_move(col, lat, kind);
    checks++;
    if (kind !== 2 || lat !== exp_lat) begin
      errors++;
      $display("FAIL reject col=%0d: kind=%0d lat=%0d want kind=2 lat=%0d", col, kind, lat, exp_lat);
    end
    @(negedge clk);
    checks++;
    if (board_flat !== exp_flat() || cur_player !== player_before) begin
      errors++;
      $display("FAIL reject_side_effect col=%0d: board=%h player=%b want board=%h player=%b",
               col, board_flat, cur_player, exp_flat(), player_before);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    new_game = 1'b0;
    game_over = 1'b0;
    move_valid = 1'b0;
    move_col = 3'd0;
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (board_flat !== '0) begin errors++; $display("FAIL reset_board: got %h want 0", board_flat); end
    checks++;
    if (cur_player !== 2'b01) begin errors++; $display("FAIL reset_cur_player: got %b want 01", cur_player); end
    checks++;
    if (place_valid !== 1'b0 || move_err !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: place_valid=%b move_err=%b want 0 0", place_valid, move_err);
    end
    checks++;
    if (move_ready !== 1'b1 || board_full !== 1'b0) begin
      errors++; $display("FAIL reset_ready_full: ready=%b full=%b want 1 0", move_ready, board_full);
    end
    checks++;
    if (place_row !== 3'd0 || place_col !== 3'd0 || place_player !== 2'b00 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_place_regs: row=%0d col=%0d player=%b state=%0d want 0 0 00 IDLE",
               place_row, place_col, place_player, dbg_state);
    end
  endtask

  task automatic test_first_move();
    place_expect(3, 0, 2'b01, 2);
  endtask

  task automatic test_column_fill();
    pulse_new_game();
    place_expect(0, 0, 2'b01, 2);
    place_expect(0, 1, 2'b10, 3);
    place_expect(0, 2, 2'b01, 4);
    place_expect(0, 3, 2'b10, 5);
    place_expect(0, 4, 2'b01, 6);
    place_expect(0, 5, 2'b10, 7);
    err_expect(0, 7);
  endtask

  task automatic test_bad_col();
    err_expect(7, 2);
  endtask

  task automatic test_game_over();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    game_over = 1'b1;
    #1;
    checks++;
    if (move_ready !== 1'b0) begin errors++; $display("FAIL game_over_ready: got %b want 0", move_ready); end
    move_valid = 1'b1;
    move_col = 3'd1;
    repeat (4) begin
      @(negedge clk);
      if (place_valid || move_err || dbg_state !== ST_IDLE) seen = 1'b1;
    end
    move_valid = 1'b0;
    checks++;
    if (seen || board_flat !== exp_flat()) begin
      errors++; $display("FAIL game_over_ignore: activity=%0d board=%h want none %h", seen, board_flat, exp_flat());
    end
    game_over = 1'b0;
    @(negedge clk);
    place_expect(1, 0, 2'b01, 2);
  endtask

  task automatic test_new_game_scan();
    bit seen;
    seen = 1'b0;
    pulse_new_game();
    place_expect(2, 0, 2'b01, 2);
    place_expect(2, 1, 2'b10, 3);
    place_expect(2, 2, 2'b01, 4);
    move_valid = 1'b1;
    move_col = 3'd2;
    @(negedge clk);
    move_valid = 1'b0;
    checks++;
    if (dbg_state !== ST_SCAN) begin errors++; $display("FAIL ng_in_scan: state=%0d want SCAN", dbg_state); end
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    clear_model();
    checks++;
    if (board_flat !== '0 || dbg_state !== ST_IDLE || cur_player !== 2'b01 ||
        place_valid !== 1'b0 || move_err !== 1'b0) begin
      errors++;
      $display("FAIL ng_clear: board=%h state=%0d player=%b pv=%b err=%b want 0 IDLE 01 0 0",
               board_flat, dbg_state, cur_player, place_valid, move_err);
    end
    repeat (8) begin
      @(negedge clk);
      if (place_valid || move_err) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL ng_no_pulse: got pulse want none"); end
  endtask

  task automatic test_fill_board();
    pulse_new_game();
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) begin
        int k;
        k = c*NR + r;
        place_expect(c, r, (k % 2 == 0) ? 2'b01 : 2'b10, r + 2);
        if (k == NR*NC - 2) begin
          checks++;
          if (board_full !== 1'b0) begin errors++; $display("FAIL full_early: got %b want 0", board_full); end
        end
      end
    end
    checks++;
    if (board_full !== 1'b1 || move_ready !== 1'b0) begin
      errors++; $display("FAIL board_full: full=%b ready=%b want 1 0", board_full, move_ready);
    end
    move_valid = 1'b1;
    move_col = 3'd4;
    repeat (3) @(negedge clk);
    move_valid = 1'b0;
    checks++;
    if (dbg_state !== ST_IDLE || board_flat !== exp_flat()) begin
      errors++; $display("FAIL full_blocks_move: state=%0d board=%h", dbg_state, board_flat);
    end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_column_fill();
    test_bad_col();
    test_game_over();
    test_new_game_scan();
    test_fill_board();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
